instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Fetch stage directly downstream of the program counter in the 13-bit multi-cycle processor.
//  - Turns the current PC into an instruction-memory read, using a req/ack handshake.
//  - Latches the returned word into the instruction register and offers it to the decoder (valid/ready).
//  - Drives the PC's update-enable, PC-op and branch-target inputs once per retired instruction.
// PARAMETERS
//  ADDR_W   6   instruction-memory address width (64 instructions); address = PC[ADDR_W-1:0]
//  INSTR_W  13  instruction / PC width
//  TIMEOUT  15  cycles to wait for i_mem_ack before faulting (used only with FETCH_TIMEOUT_EN)
// PORTS
//  clk              in   1        single clock; all state on posedge
//  reset            in   1        one clock; reset is asynchronous and active-low
//  i_run            in   1        level: 1 = fetch continuously, 0 = stop after current instruction retires
//  i_PCcurr         in   INSTR_W  current PC value from the program counter
//  o_mem_addr       out  ADDR_W   instruction-memory address
//  o_mem_req        out  1        read request; held until ack
//  i_mem_ack        in   1        one-cycle pulse; i_mem_data valid in the same cycle
//  i_mem_data       in   INSTR_W  instruction word
//  o_IR             out  INSTR_W  instruction register
//  o_ir_valid       out  1        o_IR holds an unconsumed instruction
//  i_ir_ready       in   1        decoder accepts o_IR this cycle
//  i_branch_taken   in   1        qualified by i_ir_ready: consumed instruction redirects the PC
//  i_branch_target  in   ADDR_W   redirect target
//  o_PC             out  1        PC update enable; one-cycle pulse
//  o_PCop           out  1        0 = PC+1, 1 = load o_Branch
//  o_Branch         out  ADDR_W   branch target to the PC
//  o_fetch_err      out  1        sticky fault flag (0 when the feature is compiled out)
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; o_mem_req=0, o_mem_addr=0, o_IR=0, o_ir_valid=0,
//    o_PC=0, o_PCop=0, o_Branch=0, o_fetch_err=0. Reset mid-handshake drops req; a late ack is ignored.
//  FSM states: IDLE, FETCH, HOLD, UPDATE, SETTLE (encodings live in the package).
//  IDLE:   i_run=1 -> FETCH.
//  FETCH:  o_mem_req=1; o_mem_addr registered from i_PCcurr[ADDR_W-1:0] on entry.
//          On i_mem_ack: o_IR<=i_mem_data, o_ir_valid<=1, req drops next cycle -> HOLD.
//  HOLD:   o_ir_valid=1 until i_ir_ready=1. On handshake:
//          o_ir_valid<=0; o_PCop<=i_branch_taken; o_Branch<=i_branch_target -> UPDATE.
//          i_branch_taken without i_ir_ready is ignored.
//  UPDATE: o_PC=1 for exactly one cycle; the PC updates on this edge -> SETTLE.
//  SETTLE: one bubble so i_PCcurr is stable; i_run=1 -> FETCH, else -> IDLE.
//  Latency: req to IR valid = 1 cycle after ack. Minimum instruction period
//    = ack wait + 1 (HOLD) + 1 (UPDATE) + 1 (SETTLE) + 1 (FETCH).
//  Wrap: PC past 2^ADDR_W-1 aliases to address 0. No range check.
//  i_run falling during FETCH/HOLD: the current instruction completes and the PC is updated; then IDLE.
//  i_mem_ack outside FETCH is ignored. o_Branch and o_PCop hold their values outside UPDATE.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined:
//    - A watchdog counts FETCH cycles without ack.
//    - On reaching TIMEOUT: o_fetch_err<=1 (sticky until reset), req drops, state -> IDLE.
//    - While o_fetch_err=1 the FSM stays in IDLE regardless of i_run.
//  FETCH_TIMEOUT_EN undefined: no counter; FETCH waits indefinitely; o_fetch_err tied 0.
// STRUCTURE
//  Package proc_pkg:
//    - FSM state encodings (3-bit).
//    - INSTR_W and ADDR_W defaults.
//    - PCOP_INC = 1'b0, PCOP_BRANCH = 1'b1, shared with the PC and the decoder.
//  Sub-module fetch_watchdog (instantiated only under FETCH_TIMEOUT_EN):
//    - Inputs: clear, count_en.
//    - Output: expired.
//    - Counter width $clog2(TIMEOUT+1).
// TESTING
//  1 Sequential: PC=5, ack after 2 cycles with 13'h0A3 -> o_mem_addr=5, o_IR=13'h0A3,
//    o_ir_valid; on ready: one o_PC pulse with o_PCop=0.
//  2 Branch: ready with i_branch_taken=1, target=6'd40 -> o_PC pulse, o_PCop=1,
//    o_Branch=40; next FETCH has o_mem_addr=40.
//  3 Backpressure: hold i_ir_ready=0 for 10 cycles -> o_IR stable, o_ir_valid=1, no o_PC,
//    no new req; stray branch_taken ignored.
//  4 Wrap and stop: PC=13'd64 -> o_mem_addr=0. Drop i_run in HOLD -> instruction retires,
//    one o_PC pulse, then IDLE with req=0.
//  5 Reset mid-FETCH: reset low while req=1, then ack arrives -> all outputs 0, ack ignored, IDLE.
//  6 FETCH_TIMEOUT_EN, TIMEOUT=15: withhold ack -> o_fetch_err=1 after 15 FETCH cycles;
//    req=0; i_run=1 does not restart until reset.

Source files
------------

// File: rtl/proc_pkg.sv
// ----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the 13-bit multi-cycle processor front end.
//   - fetch_state_e : 3-bit encodings of the fetch FSM states
//   - INSTR_W_DEF / ADDR_W_DEF / TIMEOUT_DEF : default widths and watchdog limit
//   - PCOP_INC / PCOP_BRANCH : PC-op encoding shared by fetch, PC and decoder
//   - pcop_of() : maps a branch-taken flag onto the PC-op encoding
// ----------------------------------------------------------------------------
package proc_pkg;

  localparam int unsigned INSTR_W_DEF = 13;
  localparam int unsigned ADDR_W_DEF  = 6;
  localparam int unsigned TIMEOUT_DEF = 15;

  localparam logic PCOP_INC    = 1'b0;
  localparam logic PCOP_BRANCH = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_HOLD   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_SETTLE = 3'd4
  } fetch_state_e;

  function automatic logic pcop_of(input logic taken);
    if (taken) begin
      return PCOP_BRANCH;
    end else begin
      return PCOP_INC;
    end
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// ----------------------------------------------------------------------------
// fetch_watchdog
// Counts consecutive fetch cycles that end without a memory acknowledge and
// flags expiry on the TIMEOUT-th such cycle. Only instantiated by instr_fetch
// when FETCH_TIMEOUT_EN is defined.
// Ports:
//   clk      in  clock
//   reset    in  asynchronous active-low reset
//   clear    in  synchronous clear (fetch not in progress)
//   count_en in  a fetch cycle without acknowledge
//   expired  out high in the cycle that completes TIMEOUT unacknowledged cycles
// ----------------------------------------------------------------------------
module fetch_watchdog
  import proc_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment and saturate at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (count_en && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q already holds TIMEOUT-1 misses, so this cycle is the TIMEOUT-th.
  assign expired = count_en && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// Fetch stage behind the program counter of the 13-bit multi-cycle processor.
// Issues an instruction-memory read for the current PC (req/ack), latches the
// returned word into the instruction register, offers it to the decoder
// (valid/ready) and then pulses the PC update with the chosen PC-op/target.
//
// Optional feature: define FETCH_TIMEOUT_EN to add a watchdog that aborts a
// fetch after TIMEOUT unacknowledged cycles and raises a sticky o_fetch_err
// which parks the FSM in IDLE until reset. Without it o_fetch_err is 0.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   i_run                   1 = keep fetching, 0 = stop after current retire
//   i_PCcurr                current PC
//   o_mem_addr, o_mem_req   memory read address / request (held until ack)
//   i_mem_ack, i_mem_data   one-cycle acknowledge with read data
//   o_IR, o_ir_valid        instruction register and its valid flag
//   i_ir_ready              decoder takes o_IR this cycle
//   i_branch_taken/target   redirect request, qualified by i_ir_ready
//   o_PC, o_PCop, o_Branch  PC update pulse, op and branch target
//   o_fetch_err             sticky fetch timeout flag
// ----------------------------------------------------------------------------
module instr_fetch
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_run,
  input  logic [INSTR_W-1:0] i_PCcurr,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic               o_mem_req,
  input  logic               i_mem_ack,
  input  logic [INSTR_W-1:0] i_mem_data,
  output logic [INSTR_W-1:0] o_IR,
  output logic               o_ir_valid,
  input  logic               i_ir_ready,
  input  logic               i_branch_taken,
  input  logic [ADDR_W-1:0]  i_branch_target,
  output logic               o_PC,
  output logic               o_PCop,
  output logic [ADDR_W-1:0]  o_Branch,
  output logic               o_fetch_err
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_req_q, mem_req_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic               pc_q, pc_d;
  logic               pcop_q, pcop_d;
  logic [ADDR_W-1:0]  branch_q, branch_d;
  logic               fetch_err_q;
  logic               timeout_s;

  // Upper PC bits alias onto the same 2^ADDR_W instruction slots.
  logic unused_pc_hi_s;
  assign unused_pc_hi_s = ^i_PCcurr[INSTR_W-1:ADDR_W];

`ifdef FETCH_TIMEOUT_EN
  logic wd_clear_s;
  logic wd_count_s;
  logic fetch_err_d;

  assign wd_clear_s = (state_q != ST_FETCH);
  assign wd_count_s = (state_q == ST_FETCH) && !i_mem_ack;

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (wd_clear_s),
    .count_en (wd_count_s),
    .expired  (timeout_s)
  );

  // Sticky error: set on watchdog expiry, cleared only by reset.
  always_comb begin
    if (timeout_s) begin
      fetch_err_d = 1'b1;
    end else begin
      fetch_err_d = fetch_err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_err_q <= 1'b0;
    end else begin
      fetch_err_q <= fetch_err_d;
    end
  end
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;
  assign timeout_s   = 1'b0;
  assign fetch_err_q = 1'b0;
`endif

  // Next-state and next-output logic of the fetch FSM.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    pc_d       = 1'b0;
    pcop_d     = pcop_q;
    branch_d   = branch_q;
    case (state_q)
      // IDLE and SETTLE both launch a fetch; i_PCcurr is stable at this point.
      ST_IDLE, ST_SETTLE: begin
        if (i_run && !fetch_err_q) begin
          state_d    = ST_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = i_PCcurr[ADDR_W-1:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (i_mem_ack) begin
          ir_d       = i_mem_data;
          ir_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = ST_HOLD;
        end else if (timeout_s) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (i_ir_ready) begin
          ir_valid_d = 1'b0;
          pcop_d     = pcop_of(i_branch_taken);
          branch_d   = i_branch_target;
          pc_d       = 1'b1;
          state_d    = ST_UPDATE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      // o_PC is high during this state; the PC samples it at the closing edge.
      ST_UPDATE: begin
        state_d = ST_SETTLE;
      end
      default: begin
        state_d    = ST_IDLE;
        mem_req_d  = 1'b0;
        ir_valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= {ADDR_W{1'b0}};
      mem_req_q  <= 1'b0;
      ir_q       <= {INSTR_W{1'b0}};
      ir_valid_q <= 1'b0;
      pc_q       <= 1'b0;
      pcop_q     <= PCOP_INC;
      branch_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pc_q       <= pc_d;
      pcop_q     <= pcop_d;
      branch_q   <= branch_d;
    end
  end

  assign o_mem_addr  = mem_addr_q;
  assign o_mem_req   = mem_req_q;
  assign o_IR        = ir_q;
  assign o_ir_valid  = ir_valid_q;
  assign o_PC        = pc_q;
  assign o_PCop      = pcop_q;
  assign o_Branch    = branch_q;
  assign o_fetch_err = fetch_err_q;

endmodule
